// File: rtl/uart_rx_sequencer_if.sv
// Datapath strobes and consumer handshake between the UART RX sequencer
// (master) and the SIPO datapath / frame consumer (slave).
interface uart_rx_sequencer_if;
  logic data_shift;
  logic data_bit;
  logic frame_load;
  logic rx_valid;
  logic rx_ready;

  modport master (output data_shift, data_bit, frame_load, rx_valid, input  rx_ready);
  modport slave  (input  data_shift, data_bit, frame_load, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: 16x oversampling, mid-bit strobes into the SIPO datapath,
// parity/stop checks and valid/ready hand-off. RX_MAJORITY_VOTE_EN enables 2-of-3 voting.
module uart_rx_sequencer #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx_serial,
  input  logic                rx_enable,
  input  logic [DIV_W-1:0]    baud_div,
  input  logic                parity_en,
  input  logic                parity_odd,
  output logic                busy,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun_err,
  uart_rx_sequencer_if.master rx_if
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t           state_q, state_d;
  logic             sync1, rx_s;
  logic [DIV_W-1:0] tick_cnt, div_q, cur_div, eff_div;
  logic             tick_end, os_tick;
  logic [3:0]       os_cnt, os_d, bit_cnt, bit_d;
  logic             par_acc, par_d, bad, bad_d;
  logic             par_en_q, par_odd_q, latch;
  logic             shift_d, dbit_d, load_d, perr_d, ferr_d, ovr_d;
  logic             sample;

`ifdef RX_MAJORITY_VOTE_EN
  // Vote over os_cnt 6/7/8; START keeps counting so DATA os_cnt stays bit-aligned.
  localparam logic [3:0] START_PT = 4'd8;
  localparam logic [3:0] MID_PT   = 4'd8;
  localparam logic [3:0] DATA_OS0 = 4'd9;
  logic v6, v7;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v6 <= 1'b1;
      v7 <= 1'b1;
    end else if (os_tick) begin
      if (os_cnt == 4'd6) v6 <= rx_s;
      if (os_cnt == 4'd7) v7 <= rx_s;
    end
  end

  assign sample = (v6 & v7) | (v6 & rx_s) | (v7 & rx_s);
`else
  localparam logic [3:0] START_PT = 4'd7;
  localparam logic [3:0] MID_PT   = 4'd15;
  localparam logic [3:0] DATA_OS0 = 4'd0;

  assign sample = rx_s;
`endif

  // Live divisor only while idle; a frame runs on the value latched at its start.
  assign cur_div  = (state_q == IDLE) ? baud_div : div_q;
  assign eff_div  = (cur_div == '0) ? DIV_W'(1) : cur_div;
  assign tick_end = tick_cnt >= eff_div - DIV_W'(1);
  assign os_tick  = rx_enable && tick_end;

  always_comb begin
    state_d = state_q;
    os_d    = os_tick ? os_cnt + 4'd1 : os_cnt;
    bit_d   = bit_cnt;
    par_d   = par_acc;
    bad_d   = bad;
    latch   = 1'b0;
    shift_d = 1'b0;
    dbit_d  = 1'b0;
    load_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: if (os_tick && !rx_s) begin
        state_d = START;
        os_d    = 4'd0;
        bad_d   = 1'b0;
        latch   = 1'b1;
      end
      START: if (os_tick && os_cnt == START_PT) begin
        if (sample) state_d = IDLE;
        else begin
          state_d = DATA;
          os_d    = DATA_OS0;
          bit_d   = 4'd0;
          par_d   = 1'b0;
        end
      end
      DATA: if (os_tick && os_cnt == MID_PT) begin
        shift_d = 1'b1;
        dbit_d  = sample;
        par_d   = par_acc ^ sample;
        bit_d   = bit_cnt + 4'd1;
        if (bit_cnt == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (os_tick && os_cnt == MID_PT) begin
        if (sample != (par_acc ^ par_odd_q)) begin
          perr_d = 1'b1;
          bad_d  = 1'b1;
        end
        state_d = STOP;
      end
      STOP: if (os_tick && os_cnt == MID_PT) begin
        if (!sample) begin
          ferr_d  = 1'b1;
          state_d = WAIT_IDLE;
        end else begin
          state_d = IDLE;
          if (!bad) begin
            if (!rx_if.rx_valid || rx_if.rx_ready) load_d = 1'b1;
            else                                   ovr_d  = 1'b1;
          end
        end
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rx_enable) begin
      state_d = IDLE;
      os_d    = 4'd0;
      bit_d   = 4'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1            <= 1'b1;
      rx_s             <= 1'b1;
      state_q          <= IDLE;
      tick_cnt         <= '0;
      os_cnt           <= 4'd0;
      bit_cnt          <= 4'd0;
      par_acc          <= 1'b0;
      bad              <= 1'b0;
      div_q            <= '0;
      par_en_q         <= 1'b0;
      par_odd_q        <= 1'b0;
      busy             <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;
      overrun_err      <= 1'b0;
      rx_if.data_shift <= 1'b0;
      rx_if.data_bit   <= 1'b0;
      rx_if.frame_load <= 1'b0;
      rx_if.rx_valid   <= 1'b0;
    end else begin
      sync1            <= rx_serial;
      rx_s             <= sync1;
      tick_cnt         <= (!rx_enable || tick_end) ? '0 : tick_cnt + DIV_W'(1);
      state_q          <= state_d;
      os_cnt           <= os_d;
      bit_cnt          <= bit_d;
      par_acc          <= par_d;
      bad              <= bad_d;
      if (latch) begin
        div_q     <= baud_div;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
      end
      busy             <= (state_d != IDLE);
      parity_err       <= perr_d;
      frame_err        <= ferr_d;
      overrun_err      <= ovr_d;
      rx_if.data_shift <= shift_d;
      rx_if.data_bit   <= dbit_d;
      rx_if.frame_load <= load_d;
      // A load in the handshake cycle keeps rx_valid high for the new frame.
      rx_if.rx_valid   <= load_d | (rx_if.rx_valid & ~rx_if.rx_ready);
    end
  end

endmodule

// File: doc/uart_rx_sequencer.md
Name: uart_rx_sequencer

Overview:
Control sequencer for the UART receive datapath. Oversamples the serial line at 16x the baud rate, validates the start bit, and strobes each data bit into the SIPO datapath at mid-bit. It checks parity and the stop bit itself, then hands completed frames to the consumer over a valid/ready handshake with overrun detection.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first
DIV_W, 16, width of the baud divisor input

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_serial  input  1  raw serial line, asynchronous, idle high
rx_enable  input  1  receiver enable
baud_div  input  DIV_W  clocks per oversample tick; 0 is treated as 1
parity_en  input  1  parity bit present in frame
parity_odd  input  1  1 = odd parity, 0 = even parity
data_shift  output  1  one-cycle strobe: datapath shifts in data_bit
data_bit  output  1  sampled data bit, valid while data_shift=1
frame_load  output  1  one-cycle strobe: datapath copies SIPO contents to its output register
rx_valid  output  1  received frame available
rx_ready  input  1  consumer accepts frame
busy  output  1  high in every state except IDLE
parity_err  output  1  one-cycle pulse on parity mismatch
frame_err  output  1  one-cycle pulse when stop bit is sampled low
overrun_err  output  1  one-cycle pulse when a good frame is dropped because rx_valid is still set

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, all counters 0. Both synchronizer flops reset to 1 so no false start occurs.
- rx_serial passes through a 2-flop synchronizer to form rx_s. All sampling uses rx_s.
- Tick generator:
  - Counts 0..eff_div-1 while rx_enable=1. os_tick pulses one cycle at terminal count.
  - eff_div is baud_div, or 1 if baud_div=0.
  - baud_div, parity_en and parity_odd are latched on the IDLE->START transition. Changes mid-frame have no effect.
- os_cnt (4 bits) counts os_ticks within a bit. bit_cnt counts data bits. par_acc is the running XOR of data bits.
- States:
  - IDLE: on os_tick with rx_s=0 -> START, os_cnt=0.
  - START: on the os_tick where os_cnt=7 (mid start bit):
    - rx_s=1: false start, -> IDLE, no error.
    - rx_s=0: os_cnt=0, bit_cnt=0, par_acc=0, -> DATA.
  - DATA: on the os_tick where os_cnt=15 (mid-bit):
    - Sample the bit, pulse data_shift with data_bit=sample, update par_acc, bit_cnt++.
    - After the DATA_BITS-th bit -> PARITY if parity_en, else STOP.
  - PARITY: sample at mid-bit. Expected value is par_acc^parity_odd. On mismatch, pulse parity_err and set an internal bad flag. Then -> STOP.
  - STOP: sample at mid-bit.
    - Sample 0: pulse frame_err, -> WAIT_IDLE.
    - Sample 1 with bad flag set: -> IDLE, no frame_load.
    - Sample 1 with bad flag clear: frame accept (below), -> IDLE.
  - WAIT_IDLE: stay until rx_s=1, then -> IDLE. A held-low line (break) never retriggers START.
- Frame accept:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: pulse frame_load; rx_valid=1 from the next cycle.
  - Otherwise: no frame_load, pulse overrun_err; the existing frame is preserved.
- rx_valid clears on the cycle after rx_valid=1 and rx_ready=1, unless a frame_load occurs in that same cycle, in which case rx_valid stays 1.
- Outputs are registered. Each strobe appears exactly one cycle after the os_tick that caused it.
- rx_enable=0:
  - Tick generator, os_cnt and bit_cnt are cleared; state is forced to IDLE.
  - An in-flight frame is dropped silently: no strobes, no errors.
  - rx_valid and the handshake are unaffected.
- Bit period = 16*eff_div clocks. Mid-bit sampling gives ±7 oversample ticks of timing margin.

Optional Feature:
Macro RX_MAJORITY_VOTE_EN.
- Defined: each start, data, parity and stop decision uses a 2-of-3 majority of rx_s sampled at os_cnt 6, 7 and 8 of the bit (START uses 6/7/8 directly). The decision point moves to os_cnt=8. Single-tick glitches are rejected.
- Undefined: a single sample at the decision point given above.

Test Plan:
- baud_div=4, parity off, send 0xA5 -> 8 data_shift pulses with data_bit 1,0,1,0,0,1,0,1, spaced 64 clocks apart; one frame_load; rx_valid=1 until rx_ready.
- baud_div=4, even parity, send 0x3C with parity bit 1 -> parity_err pulse, no frame_load, return to IDLE; same byte with parity bit 0 -> frame_load.
- Line low for 3 os_ticks only -> START then IDLE; no data_shift, no errors, busy drops.
- Send 0x55 with stop bit 0, then hold the line low for 5 bit times -> frame_err once; remains in WAIT_IDLE with no retrigger; IDLE once line returns high.
- Two good frames with rx_ready=0 -> first frame_load, second gives overrun_err with no frame_load; rx_ready pulsed at the second stop sample -> frame_load, rx_valid stays 1.
- Assert reset=0 during bit 4 of a frame -> all outputs 0 immediately; a following clean frame is received correctly. With RX_MAJORITY_VOTE_EN, a one-tick glitch at os_cnt 7 of a data bit does not change data_bit.
